// File: rtl/game_pkg.sv
// game_pkg: shared game constants, sprite IDs and player state encoding.
package game_pkg;
  localparam int STEP_X = 6;
  localparam int V = 40;
  localparam int MAX_J = 160;
  localparam int LIMIT_X = 300;
  localparam int FIRE_COOLDOWN_DEFAULT = 12;
  typedef enum logic [3:0] {
    OBJECT_NONE           = 4'd0,
    OBJECT_PLAYER1        = 4'd1,
    OBJECT_PLAYER1_SQUAT  = 4'd2,
    OBJECT_PLAYER1_SHIELD = 4'd3,
    OBJECT_PLAYER2        = 4'd4,
    OBJECT_PLAYER2_SQUAT  = 4'd5,
    OBJECT_PLAYER2_SHIELD = 4'd6,
    OBJECT_BULLET         = 4'd7
  } ObjectID;
  typedef enum logic [2:0] {GROUND, RISE, FALL, SQUAT, SHIELD} PlayerState;
  function automatic ObjectID obj_of(input int player, input PlayerState s);
    return player == 2 ?
      (s == SQUAT ? OBJECT_PLAYER2_SQUAT : s == SHIELD ? OBJECT_PLAYER2_SHIELD : OBJECT_PLAYER2) :
      (s == SQUAT ? OBJECT_PLAYER1_SQUAT : s == SHIELD ? OBJECT_PLAYER1_SHIELD : OBJECT_PLAYER1);
  endfunction
endpackage

// File: rtl/player_motion_fire_ctrl.sv
// player_fire_ctrl: shot cooldown, shield gating, origin capture and one-cycle fire pulse.
module player_fire_ctrl
  import game_pkg::*;
#(
  parameter int FIRE_COOLDOWN = FIRE_COOLDOWN_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               tick,
  input  logic               fire_req,
  input  logic               shielded,
  input  logic signed [11:0] x,
  input  logic        [7:0]  h,
  output logic               fire,
  output logic signed [11:0] fire_x,
  output logic        [7:0]  fire_h
);
  localparam int CW = $clog2(FIRE_COOLDOWN + 1);
  logic [CW-1:0] cd;
  logic shot;
  assign shot = tick && fire_req && cd == '0 && !shielded;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cd <= '0;
      fire <= 1'b0;
      fire_x <= '0;
      fire_h <= '0;
    end else begin
      fire <= shot;
      if (shot) begin
        cd <= CW'(FIRE_COOLDOWN);
        fire_x <= x;
        fire_h <= h;
      end else if (tick && cd != '0) begin
        cd <= cd - 1'b1;
      end
    end
  end
endmodule

// File: rtl/player_motion.sv
// player_motion: per-frame player movement/jump/stance FSM with fire control.
// Define PLAYER_AIR_CONTROL_EN to allow left/right steering while airborne.
module player_motion
  import game_pkg::*;
#(
  parameter int PLAYER_NUM = 1,
  parameter logic signed [11:0] X_INIT = -12'sd200,
  parameter int FIRE_COOLDOWN = FIRE_COOLDOWN_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_frame_tick,
  input  logic               i_game_run,
  input  logic               i_left,
  input  logic               i_right,
  input  logic               i_jump,
  input  logic               i_squat,
  input  logic               i_shield,
  input  logic               i_fire,
  output logic signed [11:0] o_x,
  output logic        [7:0]  o_h,
  output logic        [3:0]  o_obj_id,
  output logic               o_fire,
  output logic signed [11:0] o_fire_x,
  output logic        [7:0]  o_fire_h
);
  localparam logic signed [12:0] STEP13 = 13'(STEP_X);
  localparam logic signed [12:0] LIM13 = 13'(LIMIT_X);
  PlayerState state, state_n;
  logic [7:0] h_n, h_dn;
  logic [8:0] h_up;
  logic launch, air, move_ok;
  logic signed [12:0] x_sum, x_clamp;
  logic signed [11:0] x_n;
  assign h_up = {1'b0, o_h} + 9'(V);
  assign h_dn = o_h - 8'(V);
  always_comb begin
    state_n = state;
    h_n = o_h;
    launch = 1'b0;
    case (state)
      GROUND: begin
        state_n = i_shield ? SHIELD : i_squat ? SQUAT : i_jump ? RISE : GROUND;
        launch = !i_shield && !i_squat && i_jump;
        h_n = launch ? 8'(V) : o_h;
      end
      SQUAT: state_n = i_squat ? SQUAT : GROUND;
      SHIELD: state_n = i_shield ? SHIELD : GROUND;
      RISE: begin
        h_n = h_up[7:0];
        state_n = h_up == 9'(MAX_J) ? FALL : RISE;
      end
      FALL: begin
        h_n = h_dn;
        state_n = h_dn == 8'd0 ? GROUND : FALL;
      end
      default: state_n = GROUND;
    endcase
  end
  // The launch tick counts as airborne so a jump is steered as one unit.
  assign air = launch || state == RISE || state == FALL;
`ifdef PLAYER_AIR_CONTROL_EN
  assign move_ok = (state == GROUND || air) && (i_left ^ i_right);
`else
  assign move_ok = state == GROUND && !launch && (i_left ^ i_right);
`endif
  always_comb begin
    x_sum = 13'(o_x) + (i_right ? STEP13 : -STEP13);
    x_clamp = x_sum > LIM13 ? LIM13 : x_sum < -LIM13 ? -LIM13 : x_sum;
    x_n = move_ok ? 12'(x_clamp) : o_x;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_game_run) begin
      state <= GROUND;
      o_x <= X_INIT;
      o_h <= '0;
      o_obj_id <= obj_of(PLAYER_NUM, GROUND);
    end else if (i_frame_tick) begin
      state <= state_n;
      o_x <= x_n;
      o_h <= h_n;
      o_obj_id <= obj_of(PLAYER_NUM, state_n);
    end
  end
  player_fire_ctrl #(.FIRE_COOLDOWN(FIRE_COOLDOWN)) u_fire (
    .clk(i_clk),
    .rst(i_rst),
    .clear(!i_game_run),
    .tick(i_frame_tick),
    .fire_req(i_fire),
    .shielded(state == SHIELD),
    .x(o_x),
    .h(o_h),
    .fire(o_fire),
    .fire_x(o_fire_x),
    .fire_h(o_fire_h)
  );
endmodule
